// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-port 32-bit RAM.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [31:0]       ls_addr,
  input  logic [31:0]       ls_wdata,
  input  logic [3:0]        ls_wstrb,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  owner_e owner_q, owner_d;
  logic   rvalid_q, rvalid_d;
  logic   force_if;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] starve_q, starve_d;

  // Reaching the limit lets fetch win; the grant itself then clears the count.
  assign force_if = (starve_q == CntW'(STARVE_MAX));

  always_comb begin
    starve_d = '0;
    if (if_req && !if_gnt) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (if_req && (!ls_req || force_if)) begin
        if_gnt   = 1'b1;
        mem_en   = 1'b1;
        mem_addr = if_addr[ADDR_W+1:2];
      end else if (ls_req) begin
        ls_gnt   = 1'b1;
        mem_addr = ls_addr[ADDR_W+1:2];
        if (ls_we) begin
          // An all-zero strobe store is accepted but never touches the RAM.
          mem_en    = |ls_wstrb;
          mem_we    = ls_wstrb;
          mem_wdata = ls_wdata;
        end else begin
          mem_en = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rvalid_d = if_gnt || (ls_gnt && !ls_we);
    owner_d  = owner_q;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (ls_gnt && !ls_we) begin
      owner_d = OWN_LS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      owner_q  <= OWN_IF;
    end else begin
      rvalid_q <= rvalid_d;
      owner_q  <= owner_d;
    end
  end

  assign if_rvalid = !rst && rvalid_q && (owner_q == OWN_IF);
  assign ls_rvalid = !rst && rvalid_q && (owner_q == OWN_LS);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              ls_addr[31:ADDR_W+2], ls_addr[1:0]};

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width of the shared RAM (4096 x 32-bit words).
REQ-002 Parameter STARVE_MAX, default 4, consecutive refused fetch cycles before fetch is forced to win (used only under REQ-030).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 if_req  input  1  instruction-fetch read request, held until granted.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  fetch read data valid.
REQ-009 if_rdata  output  32  fetch read data.
REQ-010 ls_req  input  1  load/store request, held until granted.
REQ-011 ls_we  input  1  1 = store, 0 = load.
REQ-012 ls_addr  input  32  load/store byte address.
REQ-013 ls_wdata  input  32  store data.
REQ-014 ls_wstrb  input  4  store byte enables.
REQ-015 ls_gnt  output  1  load/store request accepted this cycle.
REQ-016 ls_rvalid  output  1  load data valid.
REQ-017 ls_rdata  output  32  load data.
REQ-018 mem_en  output  1  RAM access enable.
REQ-019 mem_we  output  4  RAM byte write enables.
REQ-020 mem_addr  output  ADDR_W  RAM word address.
REQ-021 mem_wdata  output  32  RAM write data.
REQ-022 mem_rdata  input  32  RAM read data, valid one cycle after a read with mem_en high.

Function
REQ-023 Arbitration SHALL be combinational in the request cycle; at most one of if_gnt/ls_gnt high per cycle; a grant is issued every cycle a request is present (fully pipelined, back-to-back).
REQ-024 Simultaneous if_req and ls_req: ls wins (fixed priority), except as modified by REQ-030.
REQ-025 On grant: mem_en=1, mem_addr=addr[ADDR_W+1:2]; addr[1:0] and bits above ADDR_W+1 ignored (address wraps modulo RAM size).
REQ-026 Granted load/fetch: mem_we=0; a 1-bit owner register captures the winner; next cycle exactly one of if_rvalid/ls_rvalid pulses for one cycle with the matching rdata = mem_rdata.
REQ-027 Granted store: mem_we=ls_wstrb, mem_wdata=ls_wdata; no rvalid produced. Store with ls_wstrb=0 is granted with mem_en=0 (no-op).
REQ-028 No request: mem_en=0, mem_we=0, no grants; rvalid from a prior-cycle read still delivered.
REQ-029 Read-after-write same address in consecutive cycles returns the new data (RAM write-first is not required; ordering is guaranteed by issue order only).

Configuration
REQ-030 Macro ARB_STARVE_GUARD_EN: when defined, a counter (width clog2(STARVE_MAX+1)) increments each cycle if_req is high and if_gnt low, clears on if_gnt or if_req low; when counter == STARVE_MAX, fetch wins the next contention and the counter clears. When undefined, pure fixed ls priority and no counter logic is instantiated.

Reset
REQ-031 While rst high: if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we = 0; if_rdata, ls_rdata, mem_addr, mem_wdata = 0; owner and starvation counter = 0.
REQ-032 Reset asserted one cycle after a read grant suppresses that read's rvalid; first grant possible in the first cycle after rst deasserts.

Verification
REQ-033 Fetch only: if_req=1, if_addr=0x0000_0010, RAM word 4 = 0x0000_0013 -> if_gnt same cycle, mem_addr=4, if_rvalid next cycle, if_rdata=0x0000_0013.
REQ-034 Contention: if_req and ls_req (load 0x20) held together -> ls_gnt first, if_gnt next cycle; ls_rvalid then if_rvalid on consecutive cycles with correct data.
REQ-035 Store then load: store 0xDEADBEEF wstrb=0xF to 0x40, then load 0x40 -> ls_rvalid with 0xDEADBEEF; store wstrb=0x1 of 0x55 -> reload 0xDEADBE55.
REQ-036 Starvation (macro defined, STARVE_MAX=4): ls_req and if_req held continuously -> if_gnt on 5th cycle, then ls resumes; macro undefined -> if_gnt never while ls_req held.
REQ-037 Reset mid-read: grant load, assert rst next cycle -> ls_rvalid stays 0, all outputs 0 during reset.
REQ-038 Wrap: ls load at byte address 0x0000_4004 with ADDR_W=12 -> mem_addr=1.
